// File: rtl/fifo_pkg.sv
// Shared types for the FIFO write-side push controller.
//   valores_t    : data word carried from source to FIFO
//   push_t       : FIFO write strobe
//   skid_state_t : fill level of the 2-entry skid buffer
package fifo_pkg;
  localparam int DATA_W     = 8;
  localparam int SKID_DEPTH = 2;

  typedef logic [DATA_W-1:0] valores_t;
  typedef logic              push_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;
endpackage

// File: rtl/fifo_push_ctrl_if.sv
// FIFO write-side bundle.
//   push    : write strobe into the FIFO
//   data_in : word written when push is high
//   full    : FIFO full flag, returned by the FIFO
// dataOut is the producer (push controller) view, dataIn the FIFO view.
interface inFIFO import fifo_pkg::*; ();
  push_t    push;
  valores_t data_in;
  logic     full;

  modport dataOut (output push, output data_in, input  full);
  modport dataIn  (input  push, input  data_in, output full);
endinterface

// File: rtl/fifo_push_ctrl.sv
// Push controller: takes words from a valid/ready source, buffers up to two
// of them in an in-order skid pair and writes them into a FIFO whenever the
// FIFO is not full.
//   wrclk     : clock, all state on its rising edge
//   wr_rst    : asynchronous active-low reset
//   src_valid : source offers src_data
//   src_data  : offered word
//   src_ready : word is taken this cycle
//   fifo      : FIFO write side (push, data_in out; full in)
//   push_cnt  : wrapping count of completed pushes
//   busy      : skid buffer holds at least one word
module fifo_push_ctrl import fifo_pkg::*; #(
  parameter int CNT_W = 16
) (
  input  logic             wrclk,
  input  logic             wr_rst,
  input  logic             src_valid,
  input  valores_t         src_data,
  output logic             src_ready,
  inFIFO.dataOut           fifo,
  output logic [CNT_W-1:0] push_cnt,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  skid_state_t state;
  valores_t    ent0;  // head (oldest word)
  valores_t    ent1;  // second word, valid only in TWO
  logic        acc;

  // Gating with wr_rst keeps ready low during reset even though state is
  // already forced to EMPTY.
  assign src_ready    = (state != TWO) && wr_rst;
  assign acc          = src_valid && src_ready;
  assign fifo.push    = (state != EMPTY) && !fifo.full;
  // Head only moves on a push, which full blocks, so data_in is stable
  // while full is high.
  assign fifo.data_in = ent0;
  assign busy         = (state != EMPTY);

  always_ff @(posedge wrclk or negedge wr_rst) begin
    if (!wr_rst) begin
      state    <= EMPTY;
      ent0     <= '0;
      ent1     <= '0;
      push_cnt <= '0;
    end else begin
      if (fifo.push) push_cnt <= push_cnt + CNT_ONE;
      unique case (state)
        EMPTY: if (acc) begin
          ent0  <= src_data;
          state <= ONE;
        end
        ONE: begin
          unique case ({acc, fifo.push})
            2'b11: ent0 <= src_data;          // head leaves, new word becomes head
            2'b10: begin
              ent1  <= src_data;
              state <= TWO;
            end
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        TWO: if (fifo.push) begin           // no accept possible here
          ent0  <= ent1;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_ctrl.sv
// Random and directed stimulus against a queue-based model of the
// push controller: the model is a bounded FIFO of accepted words plus a
// push counter.
module tb_fifo_push_ctrl;
  import fifo_pkg::*;

  localparam int CNT_W = 4;

  logic             wrclk = 1'b0;
  logic             wr_rst = 1'b0;
  logic             src_valid = 1'b0;
  valores_t         src_data = '0;
  logic             src_ready;
  logic [CNT_W-1:0] push_cnt;
  logic             busy;

  inFIFO bus ();

  fifo_push_ctrl #(.CNT_W(CNT_W)) dut (
    .wrclk     (wrclk),
    .wr_rst    (wr_rst),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .fifo      (bus),
    .push_cnt  (push_cnt),
    .busy      (busy)
  );

  always #5 wrclk = ~wrclk;

  int       n_cmp = 0;
  int       n_err = 0;
  valores_t mq[$];
  int       m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("src_ready", 32'(src_ready), 32'(mq.size() < SKID_DEPTH));
    chk("push", 32'(bus.push), 32'(mq.size() > 0 && !bus.full));
    chk("busy", 32'(busy), 32'(mq.size() > 0));
    chk("push_cnt", 32'(push_cnt), 32'(m_cnt % (1 << CNT_W)));
    if (mq.size() > 0) chk("data_in", 32'(bus.data_in), 32'(mq[0]));
  endtask

  // Entered 1 time unit after a rising edge; returns at the same phase.
  task automatic cycle(input logic v, input valores_t d, input logic f);
    logic m_acc, m_pop;
    src_valid = v;
    src_data  = d;
    bus.full  = f;
    @(negedge wrclk);
    check_model();
    m_acc = v && (mq.size() < SKID_DEPTH);
    m_pop = (mq.size() > 0) && !f;
    @(posedge wrclk);
    #1;
    if (m_pop) begin
      void'(mq.pop_front());
      m_cnt++;
    end
    if (m_acc) mq.push_back(d);
  endtask

  initial begin
    bus.full = 1'b0;
    src_valid = 1'b1;
    src_data  = 8'hEE;
    #2;
    chk("rst_ready", 32'(src_ready), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(bus.data_in), 0);
    chk("rst_cnt", 32'(push_cnt), 0);
    @(posedge wrclk);
    #1;
    wr_rst = 1'b1;

    // streaming 0x01..0x08
    for (int i = 1; i <= 8; i++) cycle(1'b1, valores_t'(i), 1'b0);
    cycle(1'b0, '0, 1'b0);
    #2;
    chk("stream_cnt", 32'(push_cnt), 8);
    #1;

    // backpressure
    cycle(1'b1, 8'hA1, 1'b1);
    cycle(1'b1, 8'hA2, 1'b1);
    cycle(1'b1, 8'hA3, 1'b1);
    cycle(1'b1, 8'hA3, 1'b1);
    cycle(1'b1, 8'hA3, 1'b0);
    cycle(1'b1, 8'hA3, 1'b0);
    cycle(1'b0, '0, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // simultaneous accept and push in ONE
    cycle(1'b1, 8'h10, 1'b0);
    cycle(1'b1, 8'h20, 1'b0);
    cycle(1'b0, '0, 1'b0);

    // idle
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h5A, 1'b0);

    // reset with two words buffered
    cycle(1'b1, 8'h55, 1'b1);
    cycle(1'b1, 8'h66, 1'b1);
    #2;
    bus.full = 1'b0;
    src_valid = 1'b0;
    #1;
    chk("two_push", 32'(bus.push), 1);
    wr_rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(src_ready), 0);
    chk("mrst_push", 32'(bus.push), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_data", 32'(bus.data_in), 0);
    chk("mrst_cnt", 32'(push_cnt), 0);
    mq.delete();
    m_cnt = 0;
    @(posedge wrclk);
    #1;
    wr_rst = 1'b1;
    cycle(1'b1, 8'h77, 1'b0);
    #2;
    chk("post_rst_data", 32'(bus.data_in), 32'h77);
    #1;
    cycle(1'b0, '0, 1'b0);
    #2;
    chk("post_rst_cnt", 32'(push_cnt), 1);
    #1;

    // random traffic, long enough to wrap the 4-bit counter several times
    for (int i = 0; i < 500; i++)
      cycle(1'($urandom_range(0, 3) != 0), valores_t'($urandom),
            1'($urandom_range(0, 9) < 3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_push_ctrl.md
FIFO_PUSH_CTRL -- requirements
Module: fifo_push_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, the width of the push counter.
REQ-002 SHALL have port wrclk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port wr_rst, input, 1 bit; reset is asynchronous and active-low.
REQ-004 SHALL have port src_valid, input, 1 bit: the upstream source offers src_data.
REQ-005 SHALL have port src_data, input, valores_t: the word offered by the source.
REQ-006 SHALL have port src_ready, output, 1 bit: the block accepts src_data this cycle.
REQ-007 SHALL have port push, output, push_t: the write strobe to the FIFO write side.
REQ-008 SHALL have port data_in, output, valores_t: the word written to the FIFO when push is high.
REQ-009 SHALL have port full, input, 1 bit: the FIFO full flag.
REQ-010 SHALL have port push_cnt, output, CNT_W bits: the running count of completed pushes.
REQ-011 SHALL have port busy, output, 1 bit: the skid buffer holds at least one word.

Function
REQ-012 SHALL contain a 2-entry in-order skid buffer, with states EMPTY (0 words), ONE (1 word) and TWO (2 words).
REQ-013 SHALL assert src_ready combinationally when the state is not TWO and wr_rst is high.
REQ-014 SHALL accept a word in any cycle where src_valid and src_ready are both high.
REQ-015 SHALL drive push combinationally as (state != EMPTY) and not full.
REQ-016 SHALL drive data_in from the head (oldest) entry in every cycle, and SHALL hold it stable while full is high.
REQ-017 SHALL apply these transitions: accept only, state +1; push only, state -1; accept and push together, state unchanged with the head advancing; neither, hold.
REQ-018 SHALL present a word accepted in cycle N on data_in no earlier than cycle N+1 (minimum latency 1 cycle).
REQ-019 SHALL push words in exactly the order they were accepted, with no loss and no duplication.
REQ-020 SHALL never assert push while full is high, and SHALL continue to accept words until state TWO while full is high.
REQ-021 SHALL sustain 1 word/cycle when full is low and src_valid is held high.
REQ-022 SHALL increment push_cnt by 1 on every cycle with push high, and SHALL wrap modulo 2^CNT_W (all-ones goes to 0).
REQ-023 SHALL drive busy as (state != EMPTY).
REQ-024 SHALL ignore src_data whenever src_valid is low or src_ready is low.

Reset
REQ-025 SHALL, while wr_rst is low, force state EMPTY, both entries to 0, push_cnt to 0, push to 0, src_ready to 0, busy to 0 and data_in to 0.
REQ-026 SHALL discard buffered words when reset is asserted mid-operation; after release, the first push SHALL carry the first word accepted after release.
REQ-027 SHALL assert src_ready in the first cycle after wr_rst rises.

Structure
REQ-028 SHALL take valores_t and push_t from fifo_pkg.
REQ-029 SHALL define in fifo_pkg the state enum skid_state_t (EMPTY, ONE, TWO) and the constant SKID_DEPTH = 2.
REQ-030 SHALL be a single module with no sub-modules; the skid buffer is inline registers with head/tail pointers or a shift pair.
REQ-031 SHALL connect to the FIFO through the dataOut modport of inFIFO.

Verification
REQ-032 Streaming: full=0, src_valid=1 with data 0x01..0x08 back-to-back -> push high for 8 consecutive cycles starting 1 cycle after the first accept, data_in 0x01..0x08 in order, push_cnt=8.
REQ-033 Backpressure: full=1, offer 0xA1, 0xA2, 0xA3 -> 0xA1 and 0xA2 accepted, src_ready=0 while 0xA3 is held, push=0; release full -> 0xA1, 0xA2, 0xA3 pushed in order.
REQ-034 Simultaneous: state ONE holding 0x10, full=0, accept 0x20 in the same cycle -> 0x10 pushed, state stays ONE, next data_in=0x20.
REQ-035 Wrap: CNT_W=4, 17 pushes -> push_cnt reads 15 after 15 pushes, 0 after 16, 1 after 17.
REQ-036 Reset mid-stream: state TWO holding 0x55, 0x66, assert wr_rst -> all outputs 0 immediately; release and send 0x77 -> first push carries 0x77, push_cnt=1.
REQ-037 Idle: src_valid=0 -> push=0, busy=0, src_ready=1, push_cnt unchanged.
